ql_sdram_arbiter: RTL and testbench
===================================

# ql_sdram_arbiter

Shares the single SDRAM word port between the 68008 CPU bus and the HPS loader stream, which preloads RAM images during a download. It grants one access per SDRAM slot and guarantees loader forward progress under sustained CPU traffic. It holds one loader write in a buffer and back-pressures the HPS through `ld_wait`. It sits between the CPU address decode / HPS interface and the `sdram` controller, and it replaces the direct `cpu_cycle`-gated drive of the `sdram` inputs.

## Interface

Parameters:
- `AW`, 24: SDRAM word-address width.
- `CPU_AW`, 19: CPU word-address width. CPU addresses are zero-extended to `AW`.

Ports:
- `clk_sys` in 1: system clock.
- `RESET` in 1: reset, synchronous, active-high.
- `slot` in 1: one-cycle SDRAM slot strobe, every 8 clocks. This is the same strobe as the sdram `sync`.
- `cpu_req` in 1: CPU access request. Held high until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in CPU_AW: CPU word address.
- `cpu_ds` in 2: active-high byte enables, with [1] as the upper byte.
- `cpu_wdata` in 16: CPU write data.
- `cpu_rdata` out 16: registered read data.
- `cpu_ack` out 1: one-cycle completion pulse.
- `ld_wr` in 1: one-cycle loader write strobe.
- `ld_addr` in AW: loader word address.
- `ld_data` in 16: loader data.
- `ld_wait` out 1: loader buffer full. The HPS must not strobe `ld_wr` while this is high.
- `sd_addr` out AW: SDRAM address.
- `sd_din` out 16: SDRAM write data.
- `sd_ds` out 2: SDRAM byte enables.
- `sd_we` out 1: SDRAM write enable, held for the whole slot.
- `sd_oe` out 1: SDRAM read enable, held for the whole slot.
- `sd_dout` in 16: SDRAM read data. It is valid in the cycle `slot` ends a read.

## Operation

- Loader buffer: one entry, holding `lb_valid`, `lb_addr` and `lb_data`.
  - `ld_wr` while `lb_valid` = 0 captures the write and sets `lb_valid`.
  - `ld_wait` = `lb_valid`.
  - `ld_wr` while `lb_valid` = 1 is a protocol error and is dropped. The buffer is unchanged.
- The state machine has three states: IDLE, CPU_ACC and LD_ACC. All transitions happen only on cycles where `slot` = 1.
- On a `slot` cycle, the arbiter first completes the current access, then arbitrates for the next slot:
  - Completing CPU_ACC: latch `sd_dout` into `cpu_rdata` if it was a read, and pulse `cpu_ack` in the following cycle.
  - Completing LD_ACC: clear `lb_valid`. The buffer may refill from the next cycle.
  - Arbitration candidates: CPU when `cpu_req` = 1 and the CPU is not finishing an access in this same slot; loader when `lb_valid` = 1 and the loader is not finishing in this same slot.
  - Only CPU is a candidate → CPU_ACC.
  - Only loader is a candidate → LD_ACC.
  - Neither → IDLE.
  - Both are candidates → the winner is decided by the `prio_ld` flag: loader if 1, CPU if 0.
- `prio_ld` update:
  - Set when CPU wins a contended slot.
  - Cleared when the loader wins.
  - An uncontended grant leaves `prio_ld` unchanged.
  - Result: strict alternation under contention.
- Drive of the `sd_*` outputs, all registered and changing only on `slot` cycles:
  - CPU_ACC: `sd_addr` = zero-extended `cpu_addr`, `sd_ds` = `cpu_ds`, `sd_din` = `cpu_wdata`, `sd_we` = `cpu_we`, `sd_oe` = !`cpu_we`.
  - LD_ACC: `sd_addr` = `lb_addr`, `sd_ds` = 2'b11, `sd_din` = `lb_data`, `sd_we` = 1, `sd_oe` = 0.
  - IDLE: `sd_we` = `sd_oe` = 0. `sd_addr`, `sd_ds` and `sd_din` hold their last values.
- CPU inputs are sampled only on the granting `slot` cycle. Changes afterwards do not affect the access in flight.
- A `cpu_req` that drops before it is granted is simply not served.

## Timing

- Reset values: state IDLE, `sd_we` = 0, `sd_oe` = 0, `sd_addr` = 0, `sd_ds` = 0, `sd_din` = 0, `cpu_rdata` = 0, `cpu_ack` = 0, `lb_valid` = 0 (so `ld_wait` = 0), `prio_ld` = 0.
- Reset mid-access: the access is aborted and no `cpu_ack` is issued. A pending loader word is discarded. The HPS restarts the download after reset.
- Grant at slot edge S. Commands are driven from S+1 through S+8. Completion at slot S+8 and `cpu_ack` at S+9.
  - Uncontended CPU latency, from `cpu_req` sampled high at a slot to `cpu_ack`: 9 clocks.
  - Worst case with a loader pending and `prio_ld` = 1: 17 clocks.
- A back-to-back CPU request is not re-granted in the slot that completes its previous access. The CPU's minimum access period is therefore 2 slots.
- Loader throughput: at most one word per 2 slots, because the buffer clears at completion and arbitration in that same slot excludes the loader. Under CPU contention throughput is unchanged thanks to alternation.
- `ld_wait` rises in the cycle after the accepted `ld_wr`. It falls in the cycle after the completing `slot`.

## Test plan

- Reset, then idle for 32 clocks → all `sd_*` = 0, `ld_wait` = 0, no `cpu_ack`.
- CPU read: `cpu_addr` = 19'h10000, `cpu_ds` = 2'b11, with `sd_dout` = 16'hBEEF at completion → `sd_oe` held for 8 clocks, `sd_addr` = 24'h010000, `cpu_rdata` = 16'hBEEF, `cpu_ack` 9 clocks after the grant slot.
- Loader burst of 4 writes to 24'h000100..103 with data 16'h0001..0004, honouring `ld_wait` → 4 `sd_we` slots with `sd_ds` = 2'b11 and matching address/data, in order, one every 2 slots.
- Contention: `cpu_req` held high continuously with the loader streaming 6 words → grants alternate CPU, LD, CPU, LD… Every loader word is written and no CPU request waits more than 17 clocks.
- CPU byte write `cpu_ds` = 2'b10, `cpu_wdata` = 16'hA5xx → `sd_ds` = 2'b10, `sd_we` = 1 for exactly one slot, `cpu_ack` pulse width 1.
- `RESET` asserted 3 clocks into an LD_ACC with `lb_valid` = 1 → next cycle `sd_we` = 0, `ld_wait` = 0, no further SDRAM write for that word.

Source files
------------

// File: rtl/ql_sdram_arbiter_if.sv
// Bundle of CPU, HPS-loader and SDRAM word-port signals around the SDRAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ql_sdram_arbiter_if #(
    parameter int AW     = 24,
    parameter int CPU_AW = 19
);
    logic              slot;
    logic              cpu_req;
    logic              cpu_we;
    logic [CPU_AW-1:0] cpu_addr;
    logic [1:0]        cpu_ds;
    logic [15:0]       cpu_wdata;
    logic [15:0]       cpu_rdata;
    logic              cpu_ack;
    logic              ld_wr;
    logic [AW-1:0]     ld_addr;
    logic [15:0]       ld_data;
    logic              ld_wait;
    logic [AW-1:0]     sd_addr;
    logic [15:0]       sd_din;
    logic [1:0]        sd_ds;
    logic              sd_we;
    logic              sd_oe;
    logic [15:0]       sd_dout;

    modport slave (
        input  slot, cpu_req, cpu_we, cpu_addr, cpu_ds, cpu_wdata,
        input  ld_wr, ld_addr, ld_data, sd_dout,
        output cpu_rdata, cpu_ack, ld_wait,
        output sd_addr, sd_din, sd_ds, sd_we, sd_oe
    );

    modport master (
        output slot, cpu_req, cpu_we, cpu_addr, cpu_ds, cpu_wdata,
        output ld_wr, ld_addr, ld_data, sd_dout,
        input  cpu_rdata, cpu_ack, ld_wait,
        input  sd_addr, sd_din, sd_ds, sd_we, sd_oe
    );
endinterface

// File: rtl/ql_sdram_arbiter.sv
// Slot-based arbiter sharing the SDRAM word port between the 68008 bus and the
// HPS loader; a one-word loader buffer plus alternating priority keeps both moving.
module ql_sdram_arbiter #(
    parameter int AW     = 24,
    parameter int CPU_AW = 19
) (
    input  logic                 clk_sys,
    input  logic                 RESET,
    ql_sdram_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        LD_ACC  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          prio_ld_q, prio_ld_d;
    logic          lb_valid_q, lb_valid_d;
    logic [AW-1:0] lb_addr_q, lb_addr_d;
    logic [15:0]   lb_data_q, lb_data_d;
    logic [AW-1:0] sd_addr_q, sd_addr_d;
    logic [15:0]   sd_din_q, sd_din_d;
    logic [1:0]    sd_ds_q, sd_ds_d;
    logic          sd_we_q, sd_we_d;
    logic          sd_oe_q, sd_oe_d;
    logic [15:0]   cpu_rdata_q, cpu_rdata_d;
    logic          cpu_ack_q, cpu_ack_d;

    logic          cpu_cand;
    logic          ld_cand;

    // A requester finishing in this slot sits out the arbitration of the same slot.
    assign cpu_cand = bus.cpu_req && (state_q != CPU_ACC);
    assign ld_cand  = lb_valid_q  && (state_q != LD_ACC);

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q     <= IDLE;
            prio_ld_q   <= 1'b0;
            lb_valid_q  <= 1'b0;
            sd_addr_q   <= '0;
            sd_din_q    <= '0;
            sd_ds_q     <= '0;
            sd_we_q     <= 1'b0;
            sd_oe_q     <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_ld_q   <= prio_ld_d;
            lb_valid_q  <= lb_valid_d;
            sd_addr_q   <= sd_addr_d;
            sd_din_q    <= sd_din_d;
            sd_ds_q     <= sd_ds_d;
            sd_we_q     <= sd_we_d;
            sd_oe_q     <= sd_oe_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
        end
    end

    // Buffer payload is only meaningful while lb_valid_q is set, so it needs no reset.
    always_ff @(posedge clk_sys) begin
        lb_addr_q <= lb_addr_d;
        lb_data_q <= lb_data_d;
    end

    always_comb begin
        state_d   = state_q;
        prio_ld_d = prio_ld_q;
        if (bus.slot) begin
            if (cpu_cand && ld_cand) begin
                if (prio_ld_q) begin
                    state_d   = LD_ACC;
                    prio_ld_d = 1'b0;
                end else begin
                    state_d   = CPU_ACC;
                    prio_ld_d = 1'b1;
                end
            end else if (cpu_cand) begin
                state_d = CPU_ACC;
            end else if (ld_cand) begin
                state_d = LD_ACC;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        lb_valid_d  = lb_valid_q;
        lb_addr_d   = lb_addr_q;
        lb_data_d   = lb_data_q;
        sd_addr_d   = sd_addr_q;
        sd_din_d    = sd_din_q;
        sd_ds_d     = sd_ds_q;
        sd_we_d     = sd_we_q;
        sd_oe_d     = sd_oe_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = 1'b0;

        if (bus.slot && (state_q == LD_ACC)) begin
            lb_valid_d = 1'b0;
        end
        // A strobe into a full buffer is dropped; lb_valid_q is still set when clearing.
        if (bus.ld_wr && !lb_valid_q) begin
            lb_valid_d = 1'b1;
            lb_addr_d  = bus.ld_addr;
            lb_data_d  = bus.ld_data;
        end

        if (bus.slot) begin
            if (state_q == CPU_ACC) begin
                cpu_ack_d = 1'b1;
                if (sd_oe_q) begin
                    cpu_rdata_d = bus.sd_dout;
                end
            end
            case (state_d)
                CPU_ACC: begin
                    sd_addr_d = AW'(bus.cpu_addr);
                    sd_ds_d   = bus.cpu_ds;
                    sd_din_d  = bus.cpu_wdata;
                    sd_we_d   = bus.cpu_we;
                    sd_oe_d   = !bus.cpu_we;
                end
                LD_ACC: begin
                    sd_addr_d = lb_addr_q;
                    sd_ds_d   = 2'b11;
                    sd_din_d  = lb_data_q;
                    sd_we_d   = 1'b1;
                    sd_oe_d   = 1'b0;
                end
                default: begin
                    sd_we_d = 1'b0;
                    sd_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.ld_wait   = lb_valid_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.sd_addr   = sd_addr_q;
    assign bus.sd_din    = sd_din_q;
    assign bus.sd_ds     = sd_ds_q;
    assign bus.sd_we     = sd_we_q;
    assign bus.sd_oe     = sd_oe_q;

endmodule

// File: tb/tb_ql_sdram_arbiter.sv
// Directed bench for ql_sdram_arbiter: reset, CPU read/write, loader burst,
// CPU/loader contention and reset during a loader access.
module tb_ql_sdram_arbiter;

    logic clk = 1'b0;
    logic RESET;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ql_sdram_arbiter_if bus ();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.slot = (cyc[2:0] == 3'd7);

    ql_sdram_arbiter dut (
        .clk_sys (clk),
        .RESET   (RESET),
        .bus     (bus)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic wait_slot();
        int n = 0;
        while (bus.slot !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        chk("slot_found", {31'd0, bus.slot}, 32'd1);
    endtask

    int n, idx, nrec, nl, nc, kind, prev, gap, last_ack, max_gap;
    int bad_zero, bad_ack, bad_wait, oe_cnt, we_cnt, ack_early, alt_bad, ld_bad, rise_bad;
    logic prev_wr;
    logic [23:0] rec_addr [4];
    logic [15:0] rec_data [4];
    logic [1:0]  rec_ds   [4];
    int          rec_cyc  [4];

    initial begin
        RESET = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_ds = 2'b00;
        bus.cpu_wdata = '0; bus.ld_wr = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.sd_dout = '0;
        repeat (3) tick();
        RESET = 1'b0;

        // Reset state and 32 idle clocks
        chk("rst_sd_addr", {8'd0, bus.sd_addr}, 32'd0);
        chk("rst_sd_we_oe", {30'd0, bus.sd_we, bus.sd_oe}, 32'd0);
        chk("rst_ld_wait", {31'd0, bus.ld_wait}, 32'd0);
        chk("rst_rdata", {16'd0, bus.cpu_rdata}, 32'd0);
        bad_zero = 0; bad_ack = 0; bad_wait = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (bus.sd_we || bus.sd_oe || bus.sd_addr != 0 || bus.sd_ds != 0 || bus.sd_din != 0)
                bad_zero++;
            if (bus.cpu_ack) bad_ack++;
            if (bus.ld_wait) bad_wait++;
        end
        chk("idle_sd_zero", bad_zero, 0);
        chk("idle_no_ack", bad_ack, 0);
        chk("idle_no_wait", bad_wait, 0);

        // CPU read of 19'h10000 returning 16'hBEEF
        wait_slot();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 19'h10000;
        bus.cpu_ds = 2'b11; bus.cpu_wdata = 16'h1234;
        tick();
        chk("rd_sd_oe", {31'd0, bus.sd_oe}, 32'd1);
        chk("rd_sd_we", {31'd0, bus.sd_we}, 32'd0);
        chk("rd_sd_addr", {8'd0, bus.sd_addr}, 32'h010000);
        chk("rd_sd_ds", {30'd0, bus.sd_ds}, 32'd3);
        bus.cpu_addr = 19'h00007;
        oe_cnt = 0; ack_early = 0;
        for (int i = 0; i < 8; i++) begin
            oe_cnt += int'(bus.sd_oe);
            ack_early += int'(bus.cpu_ack);
            bus.sd_dout = bus.slot ? 16'hBEEF : 16'h0000;
            tick();
        end
        chk("rd_oe_cycles", oe_cnt, 8);
        chk("rd_ack_early", ack_early, 0);
        chk("rd_ack", {31'd0, bus.cpu_ack}, 32'd1);
        chk("rd_rdata", {16'd0, bus.cpu_rdata}, 32'h0000BEEF);
        chk("rd_oe_off", {31'd0, bus.sd_oe}, 32'd0);
        chk("rd_addr_hold", {8'd0, bus.sd_addr}, 32'h010000);
        bus.cpu_req = 1'b0; bus.sd_dout = 16'h0000;
        tick();
        chk("rd_ack_width", {31'd0, bus.cpu_ack}, 32'd0);

        // Loader burst of four words
        idx = 0; nrec = 0; prev_wr = 1'b0; rise_bad = 0;
        for (int c = 0; c < 200 && nrec < 4; c++) begin
            if (prev_wr && !bus.ld_wait) rise_bad++;
            bus.ld_wr = 1'b0;
            prev_wr = 1'b0;
            if (!bus.ld_wait && idx < 4) begin
                bus.ld_wr = 1'b1;
                bus.ld_addr = 24'h000100 + 24'(idx);
                bus.ld_data = 16'h0001 + 16'(idx);
                prev_wr = 1'b1;
                idx++;
            end
            if (bus.slot && bus.sd_we) begin
                rec_addr[nrec] = bus.sd_addr;
                rec_data[nrec] = bus.sd_din;
                rec_ds[nrec]   = bus.sd_ds;
                rec_cyc[nrec]  = cyc;
                nrec++;
            end
            tick();
        end
        bus.ld_wr = 1'b0;
        chk("ld_count", nrec, 4);
        chk("ld_wait_rise", rise_bad, 0);
        for (int i = 0; i < 4; i++) begin
            chk("ld_addr", {8'd0, rec_addr[i]}, 32'h000100 + i);
            chk("ld_data", {16'd0, rec_data[i]}, 32'h0001 + i);
            chk("ld_ds", {30'd0, rec_ds[i]}, 32'd3);
            if (i > 0) chk("ld_gap", rec_cyc[i] - rec_cyc[i-1], 16);
        end

        // Contention: CPU request held high while the loader streams six words
        wait_slot();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_ds = 2'b01;
        bus.cpu_addr = 19'h00040; bus.cpu_wdata = 16'hC0DE;
        idx = 0; nl = 0; nc = 0; prev = 0; alt_bad = 0; ld_bad = 0;
        last_ack = cyc; max_gap = 0;
        for (int c = 0; c < 400 && nl < 6; c++) begin
            bus.ld_wr = 1'b0;
            if (!bus.ld_wait && idx < 6) begin
                bus.ld_wr = 1'b1;
                bus.ld_addr = 24'h000200 + 24'(idx);
                bus.ld_data = 16'h1000 + 16'(idx);
                idx++;
            end
            if (bus.cpu_ack) begin
                gap = cyc - last_ack;
                if (gap > max_gap) max_gap = gap;
                last_ack = cyc;
            end
            if (bus.slot) begin
                kind = (bus.sd_we && bus.sd_ds == 2'b11) ? 2 :
                       (bus.sd_we && bus.sd_ds == 2'b01) ? 1 : 0;
                if (kind != 0) begin
                    if (kind == prev) alt_bad++;
                    prev = kind;
                end
                if (kind == 2) begin
                    if (bus.sd_addr != 24'h000200 + 24'(nl) || bus.sd_din != 16'h1000 + 16'(nl))
                        ld_bad++;
                    nl++;
                end
                if (kind == 1) nc++;
            end
            tick();
        end
        bus.ld_wr = 1'b0;
        chk("ct_ld_words", nl, 6);
        chk("ct_cpu_grants", nc, 6);
        chk("ct_alternate", alt_bad, 0);
        chk("ct_ld_order", ld_bad, 0);
        chk("ct_max_ack_gap", max_gap, 16);
        n = 0;
        while (!bus.cpu_ack && n < 20) begin
            tick();
            n++;
        end
        chk("ct_final_ack", {31'd0, bus.cpu_ack}, 32'd1);
        bus.cpu_req = 1'b0;
        tick();

        // CPU upper-byte write
        wait_slot();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_ds = 2'b10;
        bus.cpu_addr = 19'h00123; bus.cpu_wdata = 16'hA55A;
        tick();
        chk("bw_sd_ds", {30'd0, bus.sd_ds}, 32'd2);
        chk("bw_sd_we", {31'd0, bus.sd_we}, 32'd1);
        chk("bw_sd_oe", {31'd0, bus.sd_oe}, 32'd0);
        chk("bw_sd_din", {16'd0, bus.sd_din}, 32'h0000A55A);
        chk("bw_sd_addr", {8'd0, bus.sd_addr}, 32'h000123);
        bus.cpu_wdata = 16'h0000; bus.cpu_ds = 2'b01;
        we_cnt = 0; n = 0;
        while (!bus.cpu_ack && n < 20) begin
            we_cnt += int'(bus.sd_we);
            tick();
            n++;
        end
        chk("bw_ack_latency", n, 8);
        chk("bw_we_cycles", we_cnt, 8);
        chk("bw_din_hold", {16'd0, bus.sd_din}, 32'h0000A55A);
        chk("bw_we_off", {31'd0, bus.sd_we}, 32'd0);
        bus.cpu_req = 1'b0;
        tick();
        chk("bw_ack_width", {31'd0, bus.cpu_ack}, 32'd0);

        // Reset three clocks into a loader access
        tick();
        bus.ld_wr = 1'b1; bus.ld_addr = 24'h000300; bus.ld_data = 16'h7777;
        tick();
        bus.ld_wr = 1'b0;
        chk("rs_ld_wait_set", {31'd0, bus.ld_wait}, 32'd1);
        wait_slot();
        tick();
        chk("rs_ld_we", {31'd0, bus.sd_we}, 32'd1);
        chk("rs_ld_addr", {8'd0, bus.sd_addr}, 32'h000300);
        tick();
        tick();
        RESET = 1'b1;
        tick();
        chk("rs_we_cleared", {31'd0, bus.sd_we}, 32'd0);
        chk("rs_wait_cleared", {31'd0, bus.ld_wait}, 32'd0);
        chk("rs_addr_cleared", {8'd0, bus.sd_addr}, 32'd0);
        RESET = 1'b0;
        bad_zero = 0; bad_ack = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (bus.sd_we) bad_zero++;
            if (bus.cpu_ack) bad_ack++;
        end
        chk("rs_no_rewrite", bad_zero, 0);
        chk("rs_no_ack", bad_ack, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
